flag_branch_unit: RTL and testbench

//  Parametrised flag-register and branch-resolution unit for the pipelined CPU. It replaces the

---
 rtl/flag_branch_unit.sv | 194 +++++++++++++++++++
 tb/tb_flag_branch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// flag_branch_unit
// Flag register (N/Z/V) with EX-stage bypass, branch condition resolution,
// B/BR target generation, fetch PC register, flush generation and the halt
// drain FSM. Sits between decode (branch request) and fetch (PC).
// Optional feature: define BRANCH_STATS_EN to build the saturating
// branch/taken statistics counters; otherwise br_cnt/taken_cnt read 0.
module flag_branch_unit #(
  parameter int                ADDR_W    = 16,
  parameter int                OFF_W     = 9,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                DRAIN_CYC = 4,
  parameter int                STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              set_n,
  input  logic              set_z,
  input  logic              set_v,
  input  logic              n_in,
  input  logic              z_in,
  input  logic              v_in,
  input  logic              br_valid,
  input  logic              br_reg,
  input  logic [2:0]        ccc,
  input  logic [ADDR_W-1:0] pc_plus2,
  input  logic [OFF_W-1:0]  offset,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc,
  output logic              flush,
  output logic [2:0]        flags,
  output logic              halted,
  output logic [STAT_W-1:0] br_cnt,
  output logic [STAT_W-1:0] taken_cnt
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  // Drain counter holds DRAIN_CYC-1 down to 0; keep at least one bit wide.
  localparam int                CNT_W      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0]  DRAIN_LOAD = (DRAIN_CYC > 0) ? CNT_W'(DRAIN_CYC - 1) : '0;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        flags_q, flags_d;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              halted_q;

  logic [2:0]        set_vec, in_vec;
  logic              n_eff, z_eff, v_eff;
  logic              cond;
  logic              run;
  logic              taken;
  logic [ADDR_W-1:0] off_sext;
  logic [ADDR_W-1:0] b_target;
  logic [ADDR_W-1:0] target;

  // Next flag value doubles as the bypassed flag seen by the condition check:
  // a flag being written this cycle is taken straight from the EX ALU.
  assign set_vec = {set_n, set_z, set_v};
  assign in_vec  = {n_in, z_in, v_in};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_flag
      assign flags_d[gi] = set_vec[gi] ? in_vec[gi] : flags_q[gi];
    end
  endgenerate

  assign n_eff = flags_d[2];
  assign z_eff = flags_d[1];
  assign v_eff = flags_d[0];

  // Condition code evaluation on the effective (bypassed) flags.
  always_comb begin
    cond = 1'b0;
    case (ccc)
      3'b000:  cond = ~z_eff;
      3'b001:  cond = z_eff;
      3'b010:  cond = ~z_eff & ~n_eff;
      3'b011:  cond = n_eff;
      3'b100:  cond = z_eff | ~n_eff;
      3'b101:  cond = n_eff | z_eff;
      3'b110:  cond = v_eff;
      default: cond = 1'b1;
    endcase
  end

  // Branch immediate is a halfword offset: sign-extend to PC width, then x2.
  generate
    if (OFF_W >= ADDR_W) begin : g_off_trunc
      assign off_sext = offset[ADDR_W-1:0];
    end else begin : g_off_sext
      assign off_sext = {{(ADDR_W - OFF_W){offset[OFF_W-1]}}, offset};
    end
  endgenerate

  assign b_target = pc_plus2 + {off_sext[ADDR_W-2:0], 1'b0};
  assign target   = br_reg ? reg_target : b_target;

  // A halt request wins over a branch in the same cycle; that branch is dropped.
  assign run   = (state_q == S_RUN);
  assign taken = br_valid & cond & ~halt_req & ~stall & run;
  assign flush = taken;

  // PC sequencing and the RUN -> DRAIN -> HALTED drain FSM.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (!stall) begin
          pc_d = taken ? target : pc_q + ADDR_W'(2);
          if (halt_req) begin
            if (DRAIN_CYC == 0) begin
              state_d = S_HALTED;
            end else begin
              state_d = S_DRAIN;
              cnt_d   = DRAIN_LOAD;
            end
          end
        end
      end
      S_DRAIN: begin
        // Drain keeps counting through stalls so the pipe empties on schedule.
        if (cnt_q == '0) begin
          state_d = S_HALTED;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_HALTED;
      end
    endcase
  end

  // State registers; flags update regardless of stall or FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      flags_q  <= 3'b000;
      state_q  <= S_RUN;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      flags_q  <= flags_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == S_HALTED);
    end
  end

  assign pc     = pc_q;
  assign flags  = flags_q;
  assign halted = halted_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] br_cnt_q;
  logic [STAT_W-1:0] taken_cnt_q;
  logic              br_count_en;

  assign br_count_en = br_valid & ~stall & run & ~halt_req;

  // Saturating statistics counters for resolved and taken branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      if (br_count_en && (br_cnt_q != '1)) begin
        br_cnt_q <= br_cnt_q + STAT_W'(1);
      end
      if (taken && (taken_cnt_q != '1)) begin
        taken_cnt_q <= taken_cnt_q + STAT_W'(1);
      end
    end
  end

  assign br_cnt    = br_cnt_q;
  assign taken_cnt = taken_cnt_q;
`else
  assign br_cnt    = '0;
  assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: reference model plus a scoreboard
// queue of expected post-edge state, with directed checks on the documented
// scenarios (bypass, conditions, stall, wrap, stats, halt drain, reset).
`timescale 1ns/1ps
module tb_flag_branch_unit;

  localparam int          ADDR_W    = 16;
  localparam int          OFF_W     = 9;
  localparam logic [15:0] RESET_PC  = 16'h0010;
  localparam int          DRAIN_CYC = 4;
  localparam int          STAT_W    = 2;
`ifdef BRANCH_STATS_EN
  localparam bit          STATS     = 1'b1;
  localparam logic [1:0]  EXP_SAT   = 2'd3;
`else
  localparam bit          STATS     = 1'b0;
  localparam logic [1:0]  EXP_SAT   = 2'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall, set_n, set_z, set_v, n_in, z_in, v_in;
  logic        br_valid, br_reg, halt_req;
  logic [2:0]  ccc;
  logic [15:0] pc_plus2, reg_target;
  logic [8:0]  offset;
  logic [15:0] pc;
  logic        flush, halted;
  logic [2:0]  flags;
  logic [1:0]  br_cnt, taken_cnt;

  always #5 clk = ~clk;

  flag_branch_unit #(
    .ADDR_W(ADDR_W), .OFF_W(OFF_W), .RESET_PC(RESET_PC),
    .DRAIN_CYC(DRAIN_CYC), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .set_n(set_n), .set_z(set_z), .set_v(set_v),
    .n_in(n_in), .z_in(z_in), .v_in(v_in),
    .br_valid(br_valid), .br_reg(br_reg), .ccc(ccc),
    .pc_plus2(pc_plus2), .offset(offset), .reg_target(reg_target),
    .halt_req(halt_req),
    .pc(pc), .flush(flush), .flags(flags), .halted(halted),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  typedef struct {
    logic [15:0] pc;
    logic [2:0]  flags;
    logic        halted;
    logic [1:0]  br;
    logic [1:0]  tk;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state (0 = RUN, 1 = DRAIN, 2 = HALTED)
  logic [15:0] m_pc;
  logic [2:0]  m_flags;
  int          m_state;
  int          m_cnt;
  logic [1:0]  m_br, m_tk;

  task automatic set_idle();
    stall = 0; set_n = 0; set_z = 0; set_v = 0; n_in = 0; z_in = 0; v_in = 0;
    br_valid = 0; br_reg = 0; ccc = 3'd0; pc_plus2 = 16'h0; offset = 9'h0;
    reg_target = 16'h0; halt_req = 0;
  endtask

  // One clock of stimulus: predict, push expectation, check flush before the
  // edge, then pop and check registered outputs just after it.
  task automatic drive_cycle(input string tag);
    logic ne, ze, ve, cond, tk;
    logic [15:0] tgt;
    exp_t e;
    int nstate, ncnt;
    ne = set_n ? n_in : m_flags[2];
    ze = set_z ? z_in : m_flags[1];
    ve = set_v ? v_in : m_flags[0];
    case (ccc)
      3'd0: cond = !ze;
      3'd1: cond = ze;
      3'd2: cond = !ze && !ne;
      3'd3: cond = ne;
      3'd4: cond = ze || !ne;
      3'd5: cond = ne || ze;
      3'd6: cond = ve;
      default: cond = 1'b1;
    endcase
    tk = br_valid && cond && !halt_req && !stall && (m_state == 0);
    if (br_reg) tgt = reg_target;
    else        tgt = pc_plus2 + {{6{offset[8]}}, offset, 1'b0};
    e.pc = m_pc; nstate = m_state; ncnt = m_cnt;
    if (m_state == 0) begin
      if (!stall) begin
        e.pc = tk ? tgt : m_pc + 16'd2;
        if (halt_req) begin
          nstate = 1; ncnt = DRAIN_CYC - 1;
        end
      end
    end else if (m_state == 1) begin
      if (ncnt == 0) nstate = 2;
      else ncnt = ncnt - 1;
    end
    e.flags  = {ne, ze, ve};
    e.halted = (nstate == 2);
    e.br = m_br; e.tk = m_tk;
    if (STATS) begin
      if (br_valid && !stall && (m_state == 0) && !halt_req && (m_br != 2'd3)) e.br = m_br + 2'd1;
      if (tk && (m_tk != 2'd3)) e.tk = m_tk + 2'd1;
    end
    sb_q.push_back(e);

    @(negedge clk);
    n_vec++;
    if (flush !== tk) begin
      n_err++; $display("FAIL %s flush: got %b want %b", tag, flush, tk);
    end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    n_vec++;
    if (pc !== e.pc) begin
      n_err++; $display("FAIL %s pc: got %h want %h", tag, pc, e.pc);
    end
    n_vec++;
    if (flags !== e.flags) begin
      n_err++; $display("FAIL %s flags: got %b want %b", tag, flags, e.flags);
    end
    n_vec++;
    if (halted !== e.halted) begin
      n_err++; $display("FAIL %s halted: got %b want %b", tag, halted, e.halted);
    end
    n_vec++;
    if (br_cnt !== e.br) begin
      n_err++; $display("FAIL %s br_cnt: got %0d want %0d", tag, br_cnt, e.br);
    end
    n_vec++;
    if (taken_cnt !== e.tk) begin
      n_err++; $display("FAIL %s taken_cnt: got %0d want %0d", tag, taken_cnt, e.tk);
    end
    $display("%-14s pc=%h flags=%b flush=%b halted=%b br=%0d tk=%0d",
             tag, pc, flags, tk, halted, br_cnt, taken_cnt);
    m_pc = e.pc; m_flags = e.flags; m_state = nstate; m_cnt = ncnt;
    m_br = e.br; m_tk = e.tk;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset(input string tag);
    set_idle();
    rst_n = 0;
    #2;
    n_vec++;
    if (pc !== RESET_PC) begin n_err++; $display("FAIL %s pc: got %h want %h", tag, pc, RESET_PC); end
    n_vec++;
    if (flags !== 3'b000) begin n_err++; $display("FAIL %s flags: got %b want 000", tag, flags); end
    n_vec++;
    if (halted !== 1'b0) begin n_err++; $display("FAIL %s halted: got %b want 0", tag, halted); end
    n_vec++;
    if (flush !== 1'b0) begin n_err++; $display("FAIL %s flush: got %b want 0", tag, flush); end
    n_vec++;
    if ((br_cnt !== 2'd0) || (taken_cnt !== 2'd0)) begin
      n_err++; $display("FAIL %s stats: got %0d/%0d want 0/0", tag, br_cnt, taken_cnt);
    end
    $display("%-14s pc=%h flags=%b halted=%b (reset)", tag, pc, flags, halted);
    m_pc = RESET_PC; m_flags = 3'b000; m_state = 0; m_cnt = 0; m_br = 2'd0; m_tk = 2'd0;
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    logic [15:0] exp_pc;
    do_reset("reset");
    exp_pc = 16'h0012;
    for (int i = 0; i < 3; i++) begin
      set_idle();
      drive_cycle("idle");
      n_vec++;
      if (pc !== exp_pc) begin n_err++; $display("FAIL idle_seq pc: got %h want %h", pc, exp_pc); end
      exp_pc = exp_pc + 16'd2;
    end
  endtask

  task automatic test_bypass();
    set_idle();
    set_z = 1; z_in = 1; br_valid = 1; ccc = 3'b001; pc_plus2 = 16'h0020; offset = 9'h1FE;
    drive_cycle("bypass_z");
    n_vec++;
    if (pc !== 16'h001C) begin n_err++; $display("FAIL bypass_target pc: got %h want 001c", pc); end
  endtask

  task automatic test_cond();
    set_idle(); set_z = 1; z_in = 0; set_n = 1; n_in = 0;
    drive_cycle("clr_nz");
    set_idle(); br_valid = 1; ccc = 3'b010; pc_plus2 = 16'h0100; offset = 9'h010;
    drive_cycle("gt_taken");
    n_vec++;
    if (pc !== 16'h0120) begin n_err++; $display("FAIL gt_taken pc: got %h want 0120", pc); end
    set_idle(); set_n = 1; n_in = 1;
    drive_cycle("set_n");
    set_idle(); br_valid = 1; ccc = 3'b010; pc_plus2 = 16'h0100; offset = 9'h010;
    drive_cycle("gt_not_taken");
    n_vec++;
    if (pc !== 16'h0124) begin n_err++; $display("FAIL gt_not_taken pc: got %h want 0124", pc); end
  endtask

  task automatic test_stall_br();
    set_idle(); br_reg = 1; br_valid = 1; ccc = 3'b111; reg_target = 16'hBEEF; stall = 1;
    set_v = 1; v_in = 1;
    drive_cycle("br_stalled");
    n_vec++;
    if (pc !== 16'h0124) begin n_err++; $display("FAIL stall_hold pc: got %h want 0124", pc); end
    stall = 0; set_v = 0;
    drive_cycle("br_released");
    n_vec++;
    if (pc !== 16'hBEEF) begin n_err++; $display("FAIL br_reg pc: got %h want beef", pc); end
  endtask

  task automatic test_wrap();
    set_idle(); br_valid = 1; ccc = 3'b111; pc_plus2 = 16'hFFFE; offset = 9'h002;
    drive_cycle("wrap_fwd");
    n_vec++;
    if (pc !== 16'h0002) begin n_err++; $display("FAIL wrap_fwd pc: got %h want 0002", pc); end
    pc_plus2 = 16'h1000; offset = 9'h0FF;
    drive_cycle("max_pos_off");
    pc_plus2 = 16'h0100; offset = 9'h100;
    drive_cycle("max_neg_off");
    n_vec++;
    if (pc !== 16'hFF00) begin n_err++; $display("FAIL max_neg_off pc: got %h want ff00", pc); end
  endtask

  task automatic test_random_cond();
    for (int i = 0; i < 32; i++) begin
      set_idle();
      {set_n, set_z, set_v} = 3'($urandom);
      {n_in, z_in, v_in}    = 3'($urandom);
      br_valid   = ($urandom_range(0, 3) != 0);
      br_reg     = 1'($urandom);
      ccc        = 3'(i);
      pc_plus2   = 16'($urandom);
      offset     = 9'($urandom);
      reg_target = 16'($urandom);
      stall      = ($urandom_range(0, 3) == 0);
      drive_cycle("rand_cond");
    end
  endtask

  task automatic test_stats();
    do_reset("stats_reset");
    set_idle(); br_valid = 1; ccc = 3'b001;  // Z clear -> not taken
    drive_cycle("stat_nt");
    set_idle(); br_valid = 1; ccc = 3'b111; stall = 1;
    drive_cycle("stat_stalled");
    stall = 0;
    for (int i = 0; i < 5; i++) begin
      pc_plus2 = 16'h0200; offset = 9'(i);
      drive_cycle("stat_taken");
    end
    n_vec++;
    if (br_cnt !== EXP_SAT) begin n_err++; $display("FAIL stat_sat br_cnt: got %0d want %0d", br_cnt, EXP_SAT); end
    n_vec++;
    if (taken_cnt !== EXP_SAT) begin n_err++; $display("FAIL stat_sat taken_cnt: got %0d want %0d", taken_cnt, EXP_SAT); end
  endtask

  task automatic test_halt();
    logic [15:0] frozen;
    set_idle(); br_valid = 1; br_reg = 1; ccc = 3'b111; reg_target = 16'h1234; halt_req = 1;
    frozen = m_pc + 16'd2;
    drive_cycle("halt_entry");
    for (int k = 1; k <= 4; k++) begin
      set_idle(); stall = (k == 2); br_valid = 1; ccc = 3'b111; br_reg = 1; reg_target = 16'h4444;
      drive_cycle("drain");
      n_vec++;
      if (halted !== (k == 4)) begin n_err++; $display("FAIL drain_len halted: got %b want %b (cycle %0d)", halted, (k == 4), k); end
      n_vec++;
      if (pc !== frozen) begin n_err++; $display("FAIL drain_pc pc: got %h want %h", pc, frozen); end
    end
    set_idle(); br_valid = 1; ccc = 3'b111; pc_plus2 = 16'h0300; set_v = 1; v_in = 0;
    drive_cycle("halted_br");
    n_vec++;
    if (pc !== frozen) begin n_err++; $display("FAIL halted_pc pc: got %h want %h", pc, frozen); end
  endtask

  task automatic test_reset_in_drain();
    do_reset("pre_drain");
    set_idle(); halt_req = 1;
    drive_cycle("halt_entry2");
    set_idle();
    drive_cycle("drain2");
    drive_cycle("drain2");
    do_reset("reset_in_drain");
    set_idle(); br_valid = 1; br_reg = 1; ccc = 3'b111; reg_target = 16'h0042;
    drive_cycle("run_after_rst");
    n_vec++;
    if (pc !== 16'h0042) begin n_err++; $display("FAIL run_after_rst pc: got %h want 0042", pc); end
  endtask

  initial begin
    set_idle();
    #1;
    test_reset();
    test_bypass();
    test_cond();
    test_stall_br();
    test_wrap();
    test_random_cond();
    test_stats();
    test_halt();
    test_reset_in_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
